// File: rtl/s_mem_phase_sequencer.sv
// Three-phase sequencer for the shared 256x8 S-memory: launches init, shuffle and decode
// phase FSMs in order, grants the memory port to the running phase and watches for timeout.
module s_mem_phase_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int NUM_PHASES     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [NUM_PHASES-1:0]      ph_start,
    input  logic [NUM_PHASES-1:0]      ph_finish,
    input  logic [NUM_PHASES-1:0]      ph_wr_en,
    input  logic [NUM_PHASES-1:0][7:0] ph_addr,
    input  logic [NUM_PHASES-1:0][7:0] ph_wr_data,
    output logic [7:0]                 mem_addr,
    output logic [7:0]                 mem_wr_data,
    output logic                       mem_wr_en,
    output logic [1:0]                 phase,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     LAST_PH = 2'(NUM_PHASES - 1);
    localparam logic [1:0]     NO_PH   = 2'd3;

    // P_START(i)/P_WAIT(i) share one state code each; the phase index lives in cur_ph.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       cur_ph, cur_ph_nx;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic             granted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cur_ph  <= 2'd0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            cur_ph  <= cur_ph_nx;
            tmo_cnt <= tmo_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cur_ph_nx  = cur_ph;
        tmo_cnt_nx = tmo_cnt;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nx   = S_START;
                    cur_ph_nx  = 2'd0;
                    tmo_cnt_nx = '0;
                end
            end
            S_START: begin
                state_nx   = S_WAIT;
                tmo_cnt_nx = '0;
            end
            S_WAIT: begin
                // finish wins over a timeout landing in the same cycle
                if (ph_finish[cur_ph]) begin
                    tmo_cnt_nx = '0;
                    if (cur_ph == LAST_PH) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx  = S_START;
                        cur_ph_nx = cur_ph + 2'd1;
                    end
                end else if (tmo_cnt == CNT_LAST) begin
                    state_nx = S_ERROR;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign granted = (state == S_START) || (state == S_WAIT);
    assign phase   = granted ? cur_ph : NO_PH;
    assign busy    = granted;
    assign done    = (state == S_DONE);
    assign error   = (state == S_ERROR);

    always_comb begin
        ph_start = '0;
        if (state == S_START) ph_start[cur_ph] = 1'b1;
    end

    // Ungranted phases are fully masked so a stray write can never reach the memory.
    always_comb begin
        mem_addr    = 8'h00;
        mem_wr_data = 8'h00;
        mem_wr_en   = 1'b0;
        if (granted) begin
            mem_addr    = ph_addr[cur_ph];
            mem_wr_data = ph_wr_data[cur_ph];
            mem_wr_en   = ph_wr_en[cur_ph];
        end
    end

endmodule

// File: tb/tb_s_mem_phase_sequencer.sv
// Scenario bench for s_mem_phase_sequencer: phase-FSM models, memory write watcher and a
// ph_start pulse scoreboard drained at the end of each scenario.
module tb_s_mem_phase_sequencer;

    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       ph_start, ph_finish;
    logic [2:0]       ph_wr_en = 3'b000;
    logic [2:0][7:0]  ph_addr = '0;
    logic [2:0][7:0]  ph_wr_data = '0;
    logic [7:0]       mem_addr, mem_wr_data;
    logic             mem_wr_en;
    logic [1:0]       phase;
    logic             busy, done, error;

    logic [2:0] model_fin = 3'b000;
    logic [2:0] stray_fin = 3'b000;
    logic [2:0] model_en  = 3'b111;
    int         cnt_dn[3];
    int         wr55 = 0;
    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;

    assign ph_finish = model_fin | stray_fin;

    wire [24:0] outs = {ph_start, mem_wr_en, mem_addr, mem_wr_data, phase, busy, done, error};
    localparam logic [24:0] RST_OUTS = {3'b000, 1'b0, 8'h00, 8'h00, 2'd3, 3'b000};

    always #5 clk = ~clk;

    s_mem_phase_sequencer #(.TIMEOUT_CYCLES(TO), .NUM_PHASES(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ph_start(ph_start), .ph_finish(ph_finish), .ph_wr_en(ph_wr_en),
        .ph_addr(ph_addr), .ph_wr_data(ph_wr_data),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .phase(phase), .busy(busy), .done(done), .error(error)
    );

    // Phase FSM models: finish pulses 10 cycles after their start pulse.
    initial begin
        for (int i = 0; i < 3; i++) cnt_dn[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                model_fin[i] = 1'b0;
                if (!rst) cnt_dn[i] = 0;
                if (cnt_dn[i] > 0) begin
                    cnt_dn[i] = cnt_dn[i] - 1;
                    if (cnt_dn[i] == 0) model_fin[i] = 1'b1;
                end
                if (ph_start[i] && model_en[i]) cnt_dn[i] = 10;
            end
        end
    end

    always @(negedge clk) if (ph_start != 3'b000) obs_q.push_back(ph_start);
    always @(posedge clk) if (mem_wr_en && mem_addr == 8'h55) wr55 <= wr55 + 1;

    task automatic test_reset();
        #2;
        n_chk++;
        if (outs !== RST_OUTS) $display("FAIL reset_outputs got=%h want=%h", outs, RST_OUTS);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, phase, ph_start} !== {1'b0, 2'd3, 3'b000})
            $display("FAIL idle_without_start got=%b%0d%b want=0 3 000", busy, phase, ph_start);
        else n_pass++;
    endtask

    task automatic test_normal_run();
        logic [2:0] got, want;
        model_en = 3'b111;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && !done; c++) @(negedge clk);
        n_chk++;
        if ({done, busy, phase} !== {1'b1, 1'b0, 2'd3})
            $display("FAIL normal_done got done=%b busy=%b phase=%0d want 1 0 3", done, busy, phase);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL normal_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL normal_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mux_isolation();
        logic [2:0] got, want;
        int w0;
        w0 = wr55;
        model_en = 3'b110;
        exp_q.push_back(3'b001);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ph_addr[0] = 8'h12; ph_wr_data[0] = 8'h34;
        ph_addr[1] = 8'h55; ph_wr_data[1] = 8'hAA;
        ph_addr[2] = 8'h55; ph_wr_data[2] = 8'hAA;
        ph_wr_en = 3'b110;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mem_wr_en, mem_addr, mem_wr_data} !== {1'b0, 8'h12, 8'h34})
            $display("FAIL mux_ungranted got en=%b a=%h d=%h want 0 12 34", mem_wr_en, mem_addr, mem_wr_data);
        else n_pass++;
        ph_wr_en = 3'b111;
        #1;
        n_chk++;
        if ({mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 8'h12, 8'h34})
            $display("FAIL mux_granted got en=%b a=%h d=%h want 1 12 34", mem_wr_en, mem_addr, mem_wr_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        ph_wr_en = 3'b000;
        @(negedge clk);
        n_chk++;
        if (wr55 !== w0) $display("FAIL mux_no_write_55 got=%0d want=%0d", wr55, w0);
        else n_pass++;
        model_en = 3'b111;
        exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        stray_fin[0] = 1'b1;
        @(negedge clk); stray_fin[0] = 1'b0;
        for (int c = 0; c < 200 && !done; c++) @(negedge clk);
        n_chk++;
        if (done !== 1'b1) $display("FAIL mux_run_done got=%b want=1", done);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL mux_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL mux_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stray_simultaneous();
        logic [2:0] got, want;
        model_en = 3'b110;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            case (k)
                3: stray_fin[2] = 1'b1;
                4: stray_fin[2] = 1'b0;
                5: start = 1'b1;
                6: start = 1'b0;
                7: begin
                    n_chk++;
                    if ({phase, busy, done, error, ph_start} !== {2'd0, 3'b100, 3'b000})
                        $display("FAIL stray_ignored got ph=%0d b=%b d=%b e=%b s=%b want 0 1 0 0 000",
                                 phase, busy, done, error, ph_start);
                    else n_pass++;
                end
                16: stray_fin[0] = 1'b1;
                17: begin
                    stray_fin[0] = 1'b0;
                    n_chk++;
                    if ({ph_start, error} !== {3'b010, 1'b0})
                        $display("FAIL finish_beats_timeout got s=%b e=%b want 010 0", ph_start, error);
                    else n_pass++;
                end
                default: ;
            endcase
        end
        model_en = 3'b111;
        for (int c = 0; c < 200 && !done; c++) @(negedge clk);
        n_chk++;
        if (done !== 1'b1) $display("FAIL stray_run_done got=%b want=1", done);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL stray_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL stray_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        logic [2:0] got, want;
        model_en = 3'b101;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        ph_addr[1] = 8'h20; ph_wr_data[1] = 8'h5A; ph_wr_en = 3'b010;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40 && ph_start !== 3'b010; c++) @(negedge clk);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_chk++;
                if ({mem_wr_en, mem_addr} !== {1'b1, 8'h20})
                    $display("FAIL timeout_grant got en=%b a=%h want 1 20", mem_wr_en, mem_addr);
                else n_pass++;
            end
            if (k == 16) begin
                n_chk++;
                if ({error, busy} !== 2'b01) $display("FAIL timeout_early got e=%b b=%b want 0 1", error, busy);
                else n_pass++;
            end
        end
        n_chk++;
        if ({error, busy, mem_wr_en, phase} !== {3'b100, 2'd3})
            $display("FAIL timeout_error got e=%b b=%b w=%b ph=%0d want 1 0 0 3", error, busy, mem_wr_en, phase);
        else n_pass++;
        ph_wr_en = 3'b000;
        model_en = 3'b111;
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL timeout_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL timeout_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_restart();
        logic [2:0] got, want;
        model_en = 3'b111;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            n_chk++;
            if ({ph_start, done, error} !== {3'b001, 2'b00})
                $display("FAIL restart_%0d got s=%b d=%b e=%b want 001 0 0", r, ph_start, done, error);
            else n_pass++;
            for (int c = 0; c < 200 && !done; c++) @(negedge clk);
            n_chk++;
            if (done !== 1'b1) $display("FAIL restart_done_%0d got=%b want=1", r, done);
            else n_pass++;
        end
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL restart_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL restart_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        logic [2:0] got, want;
        model_en = 3'b111;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 60 && !(phase == 2'd1 && ph_start == 3'b000); c++) @(negedge clk);
        ph_wr_en = 3'b111; ph_addr[1] = 8'h77;
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (outs !== RST_OUTS) $display("FAIL async_reset got=%h want=%h", outs, RST_OUTS);
        else n_pass++;
        ph_wr_en = 3'b000;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        obs_q.delete(); exp_q.delete();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, phase, obs_q.size() == 0} !== {1'b0, 2'd3, 1'b1})
            $display("FAIL post_reset_idle got b=%b ph=%0d pulses=%0d want 0 3 0", busy, phase, obs_q.size());
        else n_pass++;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && !done; c++) @(negedge clk);
        n_chk++;
        if ({done, busy} !== 2'b10) $display("FAIL reset_rerun_done got d=%b b=%b want 1 0", done, busy);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL reset_pulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL reset_pulse got=%b want=%b", got, want);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_mux_isolation();
        test_stray_simultaneous();
        test_timeout();
        test_restart();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
